// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg: types and constants shared by the Wishbone command master.
//   state_e      - master FSM states
//   STAT_*       - response status codes returned on rsp_status_o
//   CTI/BTE      - classic-cycle burst tags driven on wb_cti_o / wb_bte_o
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StBus     = 2'b01,
    StBackoff = 2'b10,
    StResp    = 2'b11
  } state_e;

  localparam logic [1:0] STAT_OK  = 2'b00;  // terminated with ack
  localparam logic [1:0] STAT_ERR = 2'b01;  // terminated with err
  localparam logic [1:0] STAT_RTY = 2'b10;  // rty seen on every allowed attempt
  localparam logic [1:0] STAT_TMO = 2'b11;  // no termination within the timeout window

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone B3 classic-cycle master.
// Converts a valid/ready command stream into bus cycles and returns exactly one
// response per command. Handles ack/err/rty terminations, bounded retry with a
// one-cycle bus release between attempts, and a no-response timeout.
//
// Ports
//   wb_clk, wb_rst           clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake; cmd_we/adr/dat/sel_i are the fields
//   rsp_valid_o/rsp_ready_i  response handshake; rsp_dat_o, rsp_status_o are the fields
//   wb_*_o                   registered Wishbone master outputs (cti/bte tied classic)
//   wb_dat_i, wb_ack/err/rty_i  slave read data and terminations
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned dw        = 32,
  parameter int unsigned aw        = 32,
  parameter int unsigned RETRY_MAX = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  // command stream
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [dw-1:0] cmd_dat_i,
  input  logic [3:0]    cmd_sel_i,
  // response stream
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [dw-1:0] rsp_dat_o,
  output logic [1:0]    rsp_status_o,
  // Wishbone master
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  // Counters keep at least one bit so zero-valued parameters still elaborate.
  localparam int unsigned RtyW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RtyW-1:0] RtyMax = RtyW'(RETRY_MAX);
  localparam logic [TmoW-1:0] TmoLim = TmoW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [aw-1:0]   adr_q, adr_d;
  logic [dw-1:0]   dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [dw-1:0]   rsp_dat_q, rsp_dat_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic [RtyW-1:0] retry_cnt_q, retry_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TmoW-1:0] tmo_next;

  assign tmo_next = tmo_cnt_q + TmoW'(1);

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    retry_cnt_d  = retry_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
          we_d        = cmd_we_i;
          retry_cnt_d = '0;
          tmo_cnt_d   = '0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          state_d     = StBus;
        end
      end

      StBus: begin
        // Terminations beat the timeout, with priority err > ack > rty.
        if (wb_err_i) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STAT_ERR;
          rsp_dat_d    = '0;
          state_d      = StResp;
        end else if (wb_ack_i) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STAT_OK;
          rsp_dat_d    = we_q ? '0 : wb_dat_i;
          state_d      = StResp;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (retry_cnt_q < RtyMax) begin
            retry_cnt_d = retry_cnt_q + RtyW'(1);
            state_d     = StBackoff;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = STAT_RTY;
            rsp_dat_d    = '0;
            state_d      = StResp;
          end
        end else if ((TIMEOUT != 0) && (tmo_next == TmoLim)) begin
          // tmo_next == TIMEOUT here means cyc has been high for TIMEOUT cycles.
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STAT_TMO;
          rsp_dat_d    = '0;
          state_d      = StResp;
        end else begin
          tmo_cnt_d = tmo_next;
        end
      end

      StBackoff: begin
        // Bus released for exactly this one cycle; fields stay latched.
        tmo_cnt_d = '0;
        cyc_d     = 1'b1;
        stb_d     = 1'b1;
        state_d   = StBus;
      end

      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q      <= StIdle;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= STAT_OK;
      retry_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      retry_cnt_q  <= retry_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign wb_we_o      = we_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_cti_o     = CTI_CLASSIC;
  assign wb_bte_o     = BTE_LINEAR;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench for wb_cmd_master with a behavioural slave
// (4-register slave at 0x9000_0000 with registered ack, plus err / rty / silent
// modes) and a scoreboard of expected responses.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;

  always #5 wb_clk = ~wb_clk;

  wb_cmd_master #(
    .dw       (32),
    .aw       (32),
    .RETRY_MAX(4),
    .TIMEOUT  (16)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cti_o    (wb_cti_o),
    .wb_bte_o    (wb_bte_o),
    .wb_dat_i    (s_dat),
    .wb_ack_i    (s_ack),
    .wb_err_i    (s_err),
    .wb_rty_i    (s_rty)
  );

  // ---------------- behavioural slave ----------------
  typedef enum int {MReg, MErr, MRty, MSilent} smode_e;
  smode_e      mode = MReg;
  int unsigned rty_limit = 0;     // attempts numbered <= rty_limit get rty
  int unsigned attempts = 0;      // strobes the slave has terminated
  int unsigned cyc_samples = 0;   // clock edges seen with cyc high
  logic [31:0] regs [4];

  always @(posedge wb_clk) begin
    if (wb_cyc_o) cyc_samples <= cyc_samples + 1;
    if (wb_rst) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_rty <= 1'b0;
      s_dat <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_rty <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !(s_ack || s_err || s_rty) && mode != MSilent) begin
        attempts <= attempts + 1;
        s_dat    <= regs[wb_adr_o[3:2]];
        if (mode == MErr) begin
          s_err <= 1'b1;
          s_dat <= 32'hBAD0_BAD0;
        end else if (mode == MRty && (attempts + 1) <= rty_limit) begin
          s_rty <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          if (wb_we_o)
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) regs[wb_adr_o[3:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end
      end
    end
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] dat;
  } exp_t;
  exp_t        sb[$];
  exp_t        last_exp;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc_base = 0;
  int unsigned att_base = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] st, input logic [31:0] dat);
    exp_t e;
    e.st  = st;
    e.dat = dat;
    sb.push_back(e);
  endtask

  // Present a command, wait (bounded) for acceptance, then check the bus fields.
  task automatic send(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    int n = 0;
    @(negedge wb_clk);
    cyc_base    = cyc_samples;
    att_base    = attempts;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    while (!cmd_ready_o && n < 50) begin
      @(negedge wb_clk);
      n++;
    end
    check({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
    @(negedge wb_clk);
    cmd_valid_i = 1'b0;
    check({tag, "_cyc"}, 64'({wb_cyc_o, wb_stb_o}), 64'd3);
    check({tag, "_fields"}, {wb_adr_o, wb_dat_o}, {adr, dat});
    check({tag, "_selwe"}, 64'({wb_sel_o, wb_we_o}), 64'({sel, we}));
  endtask

  // Wait (bounded) for the response, compare against the scoreboard, and
  // complete the handshake if rsp_ready is high.
  task automatic wait_rsp(input string tag, input int lat, input int cycs, input int atts);
    int n = 0;
    while (!rsp_valid_o && n < 200) begin
      @(negedge wb_clk);
      n++;
    end
    check({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_cyc_low"}, 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    check({tag, "_cyc_cycles"}, 64'(cyc_samples - cyc_base), 64'(cycs));
    check({tag, "_attempts"}, 64'(attempts - att_base), 64'(atts));
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      last_exp = sb.pop_front();
      check({tag, "_status"}, 64'(rsp_status_o), 64'(last_exp.st));
      check({tag, "_dat"}, 64'(rsp_dat_o), 64'(last_exp.dat));
    end
    if (rsp_ready_i) begin
      @(negedge wb_clk);
      check({tag, "_done"}, 64'({rsp_valid_o, cmd_ready_o}), 64'b01);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge wb_clk);
    check("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
    check("rst_fields", {wb_adr_o, wb_dat_o}, 64'd0);
    check("rst_rsp", {rsp_valid_o, rsp_status_o, rsp_dat_o}, 64'd0);
    check("rst_cti_bte", 64'({wb_cti_o, wb_bte_o}), 64'd0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check("post_rst_ready", 64'(cmd_ready_o), 64'd1);

    // Register slave: full write then read back
    mode = MReg;
    expect_rsp(STAT_OK, 32'h0);
    send("wr1", 1'b1, 32'h9000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_rsp("wr1", 2, 2, 1);
    expect_rsp(STAT_OK, 32'hDEAD_BEEF);
    send("rd1", 1'b0, 32'h9000_0004, 32'h0, 4'hF);
    wait_rsp("rd1", 2, 2, 1);

    // Byte-lane write merges into the existing word
    expect_rsp(STAT_OK, 32'h0);
    send("wr2", 1'b1, 32'h9000_0008, 32'h1122_3344, 4'hF);
    wait_rsp("wr2", 2, 2, 1);
    expect_rsp(STAT_OK, 32'h0);
    send("wr3", 1'b1, 32'h9000_0008, 32'h0000_00AA, 4'h1);
    wait_rsp("wr3", 2, 2, 1);
    expect_rsp(STAT_OK, 32'h1122_33AA);
    send("rd2", 1'b0, 32'h9000_0008, 32'h0, 4'hF);
    wait_rsp("rd2", 2, 2, 1);

    // Error termination on the first strobe
    mode = MErr;
    expect_rsp(STAT_ERR, 32'h0);
    send("err", 1'b0, 32'h9000_0004, 32'h0, 4'hF);
    wait_rsp("err", 2, 2, 1);

    // Three retries then ack: 4 attempts, one idle cycle between each
    mode      = MRty;
    rty_limit = attempts + 3;
    expect_rsp(STAT_OK, 32'hDEAD_BEEF);
    send("rty3", 1'b0, 32'h9000_0004, 32'h0, 4'hF);
    wait_rsp("rty3", 11, 8, 4);

    // Always retry: exhausted after RETRY_MAX+1 = 5 attempts
    rty_limit = 32'hFFFF_0000;
    expect_rsp(STAT_RTY, 32'h0);
    send("rty_all", 1'b0, 32'h9000_0004, 32'h0, 4'hF);
    wait_rsp("rty_all", 14, 10, 5);

    // Silent slave: timeout after 16 cycles of cyc, then hold the response
    mode        = MSilent;
    rsp_ready_i = 1'b0;
    expect_rsp(STAT_TMO, 32'h0);
    send("tmo", 1'b1, 32'h9000_000C, 32'h5555_AAAA, 4'hF);
    wait_rsp("tmo", 16, 16, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      check("hold_valid_ready", 64'({rsp_valid_o, cmd_ready_o}), 64'b10);
      check("hold_rsp", 64'({rsp_status_o, rsp_dat_o}), 64'({last_exp.st, last_exp.dat}));
    end
    rsp_ready_i = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    check("hold_release", 64'({rsp_valid_o, cmd_ready_o}), 64'b01);

    // Reset one cycle into BUS: outputs clear immediately, response discarded
    send("rst_mid", 1'b0, 32'h9000_0000, 32'h0, 4'hF);
    wb_rst = 1'b1;
    #1;
    check("rst_mid_async", 64'({wb_cyc_o, wb_stb_o, rsp_valid_o}), 64'd0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    check("rst_mid_sb_empty", 64'(sb.size()), 64'd0);

    // Normal operation after the mid-flight reset
    mode = MReg;
    expect_rsp(STAT_OK, 32'h0);
    send("wr_after", 1'b1, 32'h9000_000C, 32'h0BAD_F00D, 4'hF);
    wait_rsp("wr_after", 2, 2, 1);
    expect_rsp(STAT_OK, 32'h0BAD_F00D);
    send("rd_after", 1'b0, 32'h9000_000C, 32'h0, 4'hF);
    wait_rsp("rd_after", 2, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
